scalar_multiply: RTL and testbench

Sequential vector-by-scalar multiplier: multiplies each element of an `ARR` vector by a signed 32-bit scalar, LANES elements per clock. It is the inverse-direction companion to the combinational vector/scalar divide in the neuron datapath, used for weight scaling and de-normalisation. Its `ARR` output is type-compatible with every other vector block. It replaces a combinational `MAX_NEURONS`-wide multiplier array with a small, time-multiplexed one and provides a start/valid handshake.

---
 rtl/scalar_multiply.sv | 146 ++++++++++++++
 tb/tb_scalar_multiply.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_multiply.sv
// scalar_multiply
//   Sequential vector-by-scalar multiplier. Each element of a MAX_NEURONS-wide
//   vector of signed 32-bit integers is multiplied by a signed 32-bit scalar,
//   LANES elements per clock. Products are either clamped to the signed 32-bit
//   range (SATURATE=1) or wrapped to their low 32 bits (SATURATE=0).
//   Partial results build up in a shadow vector. The visible output is loaded
//   only on the completion edge, which is also when valid pulses.
//
// Parameters
//   LANES     elements multiplied per clock; must divide MAX_NEURONS
//   SATURATE  1: clamp products to signed 32-bit, 0: keep low 32 bits
//
// Ports
//   CLK      in   rising-edge clock
//   RST_N    in   synchronous active-low reset
//   vector1  in   operand vector, latched when a start is accepted
//   scalar   in   signed multiplier, latched when a start is accepted
//   start    in   request; accepted only in IDLE
//   busy     out  high in RUN and DONE
//   valid    out  one-cycle pulse when out holds a new result
//   out      out  registered result vector
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands are latched on the accepting edge
// RUN   | one chunk of LANES products written into shadow per edge
// DONE  | result visible on out, valid high for this single cycle

`ifndef MAX_NEURONS
`define MAX_NEURONS 8
`endif

module scalar_multiply #(
  parameter int LANES    = 1,
  parameter bit SATURATE = 1'b1
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [`MAX_NEURONS-1:0][31:0] vector1,
  input  logic signed [31:0]            scalar,
  input  logic                          start,
  output logic                          busy,
  output logic                          valid,
  output logic [`MAX_NEURONS-1:0][31:0] out
);

  localparam int NN = `MAX_NEURONS;
  localparam int AW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NN - LANES);
  localparam logic [AW-1:0] LANE_STEP = AW'(LANES);

  if (LANES < 1 || (NN % LANES) != 0) begin : g_bad_lanes
    $error("scalar_multiply: LANES must be a positive divisor of MAX_NEURONS");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NN-1:0][31:0] vec_q;
  logic [NN-1:0][31:0] shadow;
  logic [NN-1:0][31:0] shadow_nxt;
  logic signed [31:0]  scl_q;
  logic [AW-1:0]       idx;
  logic                last_chunk;
  logic signed [63:0]  prod;

  function automatic logic [31:0] clamp(input logic signed [63:0] p);
    if (SATURATE) begin
      if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (p < -64'sd2147483648) return 32'h8000_0000;
    end
    return p[31:0];
  endfunction

  assign last_chunk = (idx == LAST_IDX);
  assign busy       = (state != IDLE);

  // Shadow with the current chunk merged in; feeds both shadow and, on the
  // last chunk, out, so the final chunk is visible on the completion edge.
  always_comb begin
    shadow_nxt = shadow;
    prod       = '0;
    for (int k = 0; k < LANES; k++) begin
      prod = 64'($signed(vec_q[idx + AW'(k)])) * 64'(scl_q);
      shadow_nxt[idx + AW'(k)] = clamp(prod);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      idx    <= '0;
      valid  <= 1'b0;
      out    <= '0;
      shadow <= '0;
      vec_q  <= '0;
      scl_q  <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec_q <= vector1;
            scl_q <= scalar;
            idx   <= '0;
          end
        end
        RUN: begin
          shadow <= shadow_nxt;
          if (last_chunk) begin
            out   <= shadow_nxt;
            valid <= 1'b1;
            idx   <= '0;
          end else begin
            idx <= idx + LANE_STEP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_multiply.sv
// Testbench for scalar_multiply. Four instances share one stimulus stream:
// LANES 1/2/4 with saturation and LANES 1 with wrap. A timeline reference
// model predicts per instance when a start is accepted, when the result
// lands and what it is; valid, busy and out are compared every cycle.

`ifndef MAX_NEURONS
`define MAX_NEURONS 8
`endif

module tb_scalar_multiply;

  localparam int NN = `MAX_NEURONS;
  localparam int ND = 4;
  localparam int LANES_OF [ND] = '{1, 2, 4, 1};
  localparam bit SAT_OF   [ND] = '{1'b1, 1'b1, 1'b1, 1'b0};

  typedef logic [NN-1:0][31:0] arr_t;

  typedef struct {
    arr_t        vec;
    logic [31:0] scl;
    arr_t        exp_sat;
    arr_t        exp_wrap;
  } vec_rec_t;

  logic          clk;
  logic          rst_n;
  arr_t          vector1;
  logic [31:0]   scalar;
  logic          start;
  logic [ND-1:0] busy;
  logic [ND-1:0] valid;
  arr_t          out_v [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    scalar_multiply #(
      .LANES   (LANES_OF[g]),
      .SATURATE(SAT_OF[g])
    ) dut (
      .CLK    (clk),
      .RST_N  (rst_n),
      .vector1(vector1),
      .scalar (scalar),
      .start  (start),
      .busy   (busy[g]),
      .valid  (valid[g]),
      .out    (out_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks;
  int     errors;
  longint t;
  longint free_at    [ND];
  longint done_at    [ND];
  arr_t   out_exp    [ND];
  arr_t   res_pend   [ND];
  int     valid_seen [ND];
  vec_rec_t tbl [5];

  function automatic arr_t ref_mul(arr_t v, logic [31:0] s, bit sat);
    arr_t        r;
    longint      p;
    logic [63:0] pb;
    for (int i = 0; i < NN; i++) begin
      p = longint'($signed(v[i])) * longint'($signed(s));
      if (sat && p > 64'sd2147483647) p = 64'sd2147483647;
      else if (sat && p < -64'sd2147483648) p = -64'sd2147483648;
      pb = p;
      r[i] = pb[31:0];
    end
    return r;
  endfunction

  task automatic check_bit(string name, int d, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0d got %b want %b", name, d, t, act, exp);
    end
  endtask

  task automatic check_int(string name, int d, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0d got %0d want %0d", name, d, t, act, exp);
    end
  endtask

  task automatic check_arr(string name, int d, arr_t act, arr_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0d got %h want %h", name, d, t, act, exp);
    end
  endtask

  // One clock: update the model with the inputs present at the edge, then
  // compare every instance on the following falling edge.
  task automatic step();
    @(posedge clk);
    t++;
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        free_at[d] = 0;
        done_at[d] = -1;
        out_exp[d] = '0;
      end else begin
        if (t == done_at[d]) out_exp[d] = res_pend[d];
        if (start && t >= free_at[d]) begin
          res_pend[d] = ref_mul(vector1, scalar, SAT_OF[d]);
          done_at[d]  = t + NN / LANES_OF[d];
          free_at[d]  = done_at[d] + 2;
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check_bit("valid", d, valid[d], t == done_at[d]);
      check_bit("busy", d, busy[d], t < free_at[d] - 1);
      check_arr("out", d, out_v[d], out_exp[d]);
      if (valid[d]) valid_seen[d]++;
    end
  endtask

  task automatic run_txn(arr_t v, logic [31:0] s);
    vector1 = v;
    scalar  = s;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (NN + 3) step();
  endtask

  function automatic arr_t rand_vec();
    arr_t v;
    for (int i = 0; i < NN; i++)
      v[i] = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 2000)) - 32'd1000;
    return v;
  endfunction

  function automatic logic [31:0] rand_scl();
    return ($urandom_range(0, 2) == 0) ? $urandom() : 32'($urandom_range(0, 200)) - 32'd100;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat [ND];
    int   vs  [ND];
    bit   ok;
    longint p;
    arr_t v;

    checks = 0;
    errors = 0;
    t      = 0;
    for (int d = 0; d < ND; d++) begin
      free_at[d]    = 0;
      done_at[d]    = -1;
      out_exp[d]    = '0;
      res_pend[d]   = '0;
      valid_seen[d] = 0;
    end

    // basic: (i+1) * -3
    for (int i = 0; i < NN; i++) begin
      tbl[0].vec[i]      = 32'(i + 1);
      tbl[0].exp_sat[i]  = 32'(-3 * (i + 1));
      tbl[0].exp_wrap[i] = 32'(-3 * (i + 1));
    end
    tbl[0].scl = -32'sd3;
    // saturation: 70000*70000 = 4900000000, low 32 bits = 605032704
    for (int i = 0; i < NN; i++) begin
      tbl[1].vec[i]      = 32'd5;
      tbl[1].exp_sat[i]  = 32'd350000;
      tbl[1].exp_wrap[i] = 32'd350000;
    end
    tbl[1].vec[0] = 32'd70000;
    tbl[1].vec[1] = -32'sd70000;
    tbl[1].scl    = 32'd70000;
    tbl[1].exp_sat[0]  = 32'h7FFF_FFFF;
    tbl[1].exp_sat[1]  = 32'h8000_0000;
    tbl[1].exp_wrap[0] = 32'd605032704;
    tbl[1].exp_wrap[1] = -32'sd605032704;
    // scalar 0
    for (int i = 0; i < NN; i++) begin
      tbl[2].vec[i]      = 32'(i * 1000 - 3000);
      tbl[2].exp_sat[i]  = 32'd0;
      tbl[2].exp_wrap[i] = 32'd0;
    end
    tbl[2].scl = 32'd0;
    // scalar 1 with extreme values: bit-exact copy
    for (int i = 0; i < NN; i++) tbl[3].vec[i] = 32'(i * 7919 - 11);
    tbl[3].vec[0] = 32'h8000_0000;
    tbl[3].vec[1] = 32'h7FFF_FFFF;
    tbl[3].scl      = 32'd1;
    tbl[3].exp_sat  = tbl[3].vec;
    tbl[3].exp_wrap = tbl[3].vec;
    // scalar -1: negating the most negative value is the one overflow
    for (int i = 0; i < NN; i++) begin
      tbl[4].vec[i]      = 32'(i);
      tbl[4].exp_sat[i]  = 32'(-i);
      tbl[4].exp_wrap[i] = 32'(-i);
    end
    tbl[4].vec[0]      = 32'h8000_0000;
    tbl[4].scl         = 32'hFFFF_FFFF;
    tbl[4].exp_sat[0]  = 32'h7FFF_FFFF;
    tbl[4].exp_wrap[0] = 32'h8000_0000;

    // reset held with start high: reset wins
    rst_n   = 1'b0;
    start   = 1'b1;
    vector1 = tbl[1].vec;
    scalar  = 32'd70000;
    repeat (3) step();
    for (int d = 0; d < ND; d++) begin
      check_bit("rst_busy", d, busy[d], 1'b0);
      check_bit("rst_valid", d, valid[d], 1'b0);
      check_arr("rst_out", d, out_v[d], '0);
    end

    // first accept right after release; measure latency to valid
    rst_n   = 1'b1;
    vector1 = tbl[0].vec;
    scalar  = tbl[0].scl;
    step();
    start = 1'b0;
    for (int d = 0; d < ND; d++) lat[d] = -1;
    for (int c = 1; c <= NN + 3; c++) begin
      step();
      for (int d = 0; d < ND; d++)
        if (valid[d] && lat[d] < 0) lat[d] = c;
    end
    for (int d = 0; d < ND; d++) check_int("latency", d, lat[d], NN / LANES_OF[d]);

    // directed table
    for (int r = 0; r < 5; r++) begin
      for (int d = 0; d < ND; d++) vs[d] = valid_seen[d];
      run_txn(tbl[r].vec, tbl[r].scl);
      for (int d = 0; d < ND; d++) begin
        check_arr("tbl_out", d, out_v[d], SAT_OF[d] ? tbl[r].exp_sat : tbl[r].exp_wrap);
        check_int("tbl_pulses", d, valid_seen[d] - vs[d], 1);
        if (tbl[r].scl != 0) begin
          ok = 1'b1;
          for (int i = 0; i < NN; i++) begin
            p = longint'($signed(tbl[r].vec[i])) * longint'($signed(tbl[r].scl));
            if (p <= 64'sd2147483647 && p >= -64'sd2147483648)
              if ($signed(out_v[d][i]) / $signed(tbl[r].scl) != $signed(tbl[r].vec[i])) ok = 1'b0;
          end
          check_bit("divide_back", d, ok, 1'b1);
        end
      end
    end

    // operands and start churn during RUN/DONE; held start re-accepted at E10
    vector1 = tbl[0].vec;
    scalar  = tbl[0].scl;
    start   = 1'b1;
    step();
    for (int c = 1; c <= NN + 2; c++) begin
      vector1 = rand_vec();
      scalar  = rand_scl();
      step();
      if (c == NN) begin
        check_bit("glitch_valid", 0, valid[0], 1'b1);
        check_arr("glitch_out", 0, out_v[0], tbl[0].exp_sat);
      end
      if (c == NN + 1) check_bit("glitch_idle", 0, busy[0], 1'b0);
      if (c == NN + 2) check_bit("glitch_reaccept", 0, busy[0], 1'b1);
    end
    start = 1'b0;
    repeat (NN + 3) step();

    // reset at E2 after an accept: request discarded
    vector1 = tbl[1].vec;
    scalar  = tbl[1].scl;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int d = 0; d < ND; d++) begin
      check_bit("midrst_valid", d, valid[d], 1'b0);
      check_bit("midrst_busy", d, busy[d], 1'b0);
      check_arr("midrst_out", d, out_v[d], '0);
      vs[d] = valid_seen[d];
    end
    repeat (NN + 3) step();
    for (int d = 0; d < ND; d++) check_int("midrst_no_pulse", d, valid_seen[d] - vs[d], 0);
    run_txn(tbl[1].vec, tbl[1].scl);
    for (int d = 0; d < ND; d++)
      check_arr("after_rst_out", d, out_v[d], SAT_OF[d] ? tbl[1].exp_sat : tbl[1].exp_wrap);

    // random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      v       = rand_vec();
      vector1 = v;
      scalar  = rand_scl();
      start   = ($urandom_range(0, 3) == 0);
      rst_n   = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (NN + 3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
